// File: rtl/bsg_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice: tag width,
// one-hot/binary conversion and the arbiter FSM state encoding.
package bsg_arb_pkg;

  localparam int unsigned MaxWidth = 64;

  typedef enum logic {
    StArb  = 1'b0,
    StHold = 1'b1
  } arb_state_e;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // OR of the indices of set bits; exact for one-hot inputs, 0 for all-zero.
  function automatic logic [31:0] oh_to_bin(input logic [MaxWidth-1:0] oh);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < int'(MaxWidth); i++) begin
      if (oh[i]) b = b | 32'(i);
    end
    return b;
  endfunction

  function automatic logic [MaxWidth-1:0] bin_to_oh(input logic [31:0] b);
    logic [MaxWidth-1:0] one;
    one = MaxWidth'(1);
    return one << b;
  endfunction

endpackage

// File: rtl/bsg_rr_pick.sv
// Combinational round-robin pick: lowest request strictly above last,
// wrapping to the lowest request overall.
module bsg_rr_pick import bsg_arb_pkg::*; #(
  parameter  int unsigned width_p      = 4,
  localparam int unsigned tag_width_lp = safe_clog2(width_p)
) (
  input  logic [width_p-1:0]      reqs,
  input  logic [tag_width_lp-1:0] last,
  output logic [width_p-1:0]      pick,
  output logic [tag_width_lp-1:0] tag
);

  logic [width_p-1:0] hi_mask;
  logic [width_p-1:0] hi_reqs;
  logic [width_p-1:0] cand;
  logic [width_p-1:0] cand_rev;
  logic [width_p-1:0] scan_rev;
  logic [width_p-1:0] prefix;

  always_comb begin
    hi_mask = '0;
    for (int k = 0; k < int'(width_p); k++) begin
      hi_mask[k] = (k > int'(last));
    end
    hi_reqs = reqs & hi_mask;
    cand    = (|hi_reqs) ? hi_reqs : reqs;
    cand_rev = '0;
    for (int k = 0; k < int'(width_p); k++) begin
      cand_rev[k] = cand[width_p-1-k];
    end
  end

  // The scan runs hi-to-lo, so reversing in and out yields a lo-to-hi prefix.
  bsg_scan #(
    .width_p    (width_p),
    .or_p       (1'b1),
    .and_p      (1'b0),
    .lo_to_hi_p (1'b0)
  ) u_scan (
    .i (cand_rev),
    .o (scan_rev)
  );

  always_comb begin
    prefix = '0;
    for (int k = 0; k < int'(width_p); k++) begin
      prefix[k] = scan_rev[width_p-1-k];
    end
    pick = prefix & ~(prefix << 1);
    tag  = tag_width_lp'(oh_to_bin(MaxWidth'(pick)));
  end

endmodule

// File: rtl/bsg_scan.sv
// Prefix scan (OR/AND/XOR); by default each output bit combines itself and
// every bit above it, lo_to_hi_p flips the direction.
module bsg_scan #(
  parameter int unsigned width_p    = 4,
  parameter bit          or_p       = 1'b0,
  parameter bit          and_p      = 1'b0,
  parameter bit          lo_to_hi_p = 1'b0
) (
  input  logic [width_p-1:0] i,
  output logic [width_p-1:0] o
);

  function automatic logic combine(input logic acc, input logic b);
    if (or_p)       return acc | b;
    else if (and_p) return acc & b;
    else            return acc ^ b;
  endfunction

  always_comb begin
    logic acc;
    o   = '0;
    acc = 1'b0;
    if (lo_to_hi_p) begin
      for (int k = 0; k < int'(width_p); k++) begin
        acc  = (k == 0) ? i[k] : combine(acc, i[k]);
        o[k] = acc;
      end
    end else begin
      for (int k = int'(width_p) - 1; k >= 0; k--) begin
        acc  = (k == int'(width_p) - 1) ? i[k] : combine(acc, i[k]);
        o[k] = acc;
      end
    end
  end

endmodule

// File: rtl/bsg_arb_rr_hold.sv
// Round-robin arbiter with valid/yumi handshake; optionally locks the grant
// until the consumer accepts it.
module bsg_arb_rr_hold import bsg_arb_pkg::*; #(
  parameter  int unsigned width_p      = 4,
  parameter  bit          hold_p       = 1'b1,
  localparam int unsigned tag_width_lp = safe_clog2(width_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [width_p-1:0]      reqs_i,
  output logic [width_p-1:0]      grants_o,
  output logic [tag_width_lp-1:0] tag_o,
  output logic                    v_o,
  input  logic                    yumi_i
);

  arb_state_e              state_r;
  logic [tag_width_lp-1:0] last_r;
  logic [tag_width_lp-1:0] hold_idx_r;
  logic                    hold_r;
  logic                    held_live;
  logic [width_p-1:0]      hold_oh;
  logic [width_p-1:0]      arb_pick;
  logic [tag_width_lp-1:0] arb_tag;

  bsg_rr_pick #(
    .width_p (width_p)
  ) u_pick (
    .reqs (reqs_i),
    .last (last_r),
    .pick (arb_pick),
    .tag  (arb_tag)
  );

  // A withdrawn held request falls straight back to arbitration.
  always_comb begin
    hold_r    = (state_r == StHold);
    hold_oh   = width_p'(bin_to_oh(32'(hold_idx_r)));
    held_live = hold_r & |(reqs_i & hold_oh);
    grants_o  = '0;
    tag_o     = '0;
    if (reset_n_i) begin
      grants_o = held_live ? hold_oh : arb_pick;
      tag_o    = held_live ? hold_idx_r : arb_tag;
    end
    v_o = |grants_o;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r    <= StArb;
      last_r     <= tag_width_lp'(width_p - 1);
      hold_idx_r <= '0;
    end else if (held_live) begin
      if (yumi_i) begin
        last_r  <= hold_idx_r;
        state_r <= StArb;
      end
    end else begin
      state_r <= StArb;
      if (v_o && yumi_i) begin
        last_r <= tag_o;
      end else if (v_o && hold_p) begin
        state_r    <= StHold;
        hold_idx_r <= tag_o;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i && !v_o))
        else $warning("bsg_arb_rr_hold: yumi_i asserted with no valid grant, ignored");
    end
  end

endmodule

// File: tb/tb_bsg_arb_rr_hold.sv
// Directed bench: hold_p=1 arbiter for rotation, hold, withdrawal and reset;
// a second hold_p=0 instance for the unlocked behaviour.
module tb_bsg_arb_rr_hold;

  logic       clk;
  logic       reset_n;
  logic [3:0] reqs;
  logic       yumi;
  logic [3:0] grants;
  logic [1:0] tag;
  logic       v;

  logic [3:0] reqs_b;
  logic       yumi_b;
  logic [3:0] grants_b;
  logic [1:0] tag_b;
  logic       v_b;

  int n_assert;
  int n_fail;

  bsg_arb_rr_hold #(
    .width_p (4),
    .hold_p  (1'b1)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .reqs_i    (reqs),
    .grants_o  (grants),
    .tag_o     (tag),
    .v_o       (v),
    .yumi_i    (yumi)
  );

  bsg_arb_rr_hold #(
    .width_p (4),
    .hold_p  (1'b0)
  ) dut_nohold (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .reqs_i    (reqs_b),
    .grants_o  (grants_b),
    .tag_o     (tag_b),
    .v_o       (v_b),
    .yumi_i    (yumi_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
  endtask

  // Drive at the falling edge, settle, then compare the combinational outputs.
  task automatic drive(input logic rn, input logic [3:0] r, input logic y);
    @(negedge clk);
    reset_n = rn;
    reqs    = r;
    yumi    = y;
    #1;
  endtask

  task automatic expect_a(input string name, input logic [3:0] g, input logic [1:0] t,
                          input logic vv);
    chk({name, ".grants"}, 32'(grants), 32'(g));
    chk({name, ".tag"}, 32'(tag), 32'(t));
    chk({name, ".v"}, 32'(v), 32'(vv));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    reqs     = 4'b1111;
    yumi     = 1'b1;
    reqs_b   = 4'b0000;
    yumi_b   = 1'b0;

    // Outputs forced idle while in reset, whatever the requests.
    drive(1'b0, 4'b1111, 1'b1);
    expect_a("reset0", 4'b0000, 2'd0, 1'b0);
    drive(1'b0, 4'b1111, 1'b1);
    expect_a("reset1", 4'b0000, 2'd0, 1'b0);

    // Full rotation from index 0 with every grant accepted.
    drive(1'b1, 4'b1111, 1'b1); expect_a("rot0", 4'b0001, 2'd0, 1'b1);
    drive(1'b1, 4'b1111, 1'b1); expect_a("rot1", 4'b0010, 2'd1, 1'b1);
    drive(1'b1, 4'b1111, 1'b1); expect_a("rot2", 4'b0100, 2'd2, 1'b1);
    drive(1'b1, 4'b1111, 1'b1); expect_a("rot3", 4'b1000, 2'd3, 1'b1);
    drive(1'b1, 4'b1111, 1'b1); expect_a("rot4", 4'b0001, 2'd0, 1'b1);

    // last=0: skip to index 2, then wrap to 0.
    drive(1'b1, 4'b0101, 1'b1); expect_a("skip2", 4'b0100, 2'd2, 1'b1);
    drive(1'b1, 4'b0101, 1'b1); expect_a("wrap0", 4'b0001, 2'd0, 1'b1);

    // Accept index 3 so last=3, then stall on 0011 with new requests mid-stall.
    drive(1'b1, 4'b1000, 1'b1); expect_a("to3", 4'b1000, 2'd3, 1'b1);
    drive(1'b1, 4'b0011, 1'b0); expect_a("stall0", 4'b0001, 2'd0, 1'b1);
    drive(1'b1, 4'b1011, 1'b0); expect_a("stall1", 4'b0001, 2'd0, 1'b1);
    drive(1'b1, 4'b1011, 1'b0); expect_a("stall2", 4'b0001, 2'd0, 1'b1);
    drive(1'b1, 4'b0011, 1'b1); expect_a("accept", 4'b0001, 2'd0, 1'b1);
    drive(1'b1, 4'b0011, 1'b0); expect_a("next1", 4'b0010, 2'd1, 1'b1);

    // Held on index 1; withdraw it and the arbiter picks 3 in the same cycle.
    drive(1'b1, 4'b1001, 1'b0); expect_a("withdraw", 4'b1000, 2'd3, 1'b1);
    drive(1'b1, 4'b0000, 1'b0); expect_a("withdraw_idle", 4'b0000, 2'd0, 1'b0);
    // last is still 0 after both withdrawals, so index 1 wins.
    drive(1'b1, 4'b0011, 1'b1); expect_a("last_kept", 4'b0010, 2'd1, 1'b1);

    // Hold on index 2, then reset mid-hold.
    drive(1'b1, 4'b0100, 1'b0); expect_a("hold2", 4'b0100, 2'd2, 1'b1);
    drive(1'b0, 4'b1111, 1'b0); expect_a("reset_hold", 4'b0000, 2'd0, 1'b0);
    drive(1'b1, 4'b1111, 1'b1); expect_a("post_reset", 4'b0001, 2'd0, 1'b1);

    // yumi without a valid grant is ignored: last stays 0.
    drive(1'b1, 4'b0000, 1'b1); expect_a("yumi_idle", 4'b0000, 2'd0, 1'b0);
    drive(1'b1, 4'b0011, 1'b1); expect_a("yumi_idle_after", 4'b0010, 2'd1, 1'b1);

    // hold_p=0: grant follows requests, no lock (last=3 since reset).
    drive(1'b1, 4'b0000, 1'b0);
    reqs_b = 4'b0011; yumi_b = 1'b0; #1;
    chk("nohold0.grants", 32'(grants_b), 32'h1);
    chk("nohold0.tag", 32'(tag_b), 32'h0);
    @(negedge clk);
    reqs_b = 4'b0010; #1;
    chk("nohold1.grants", 32'(grants_b), 32'h2);
    chk("nohold1.tag", 32'(tag_b), 32'h1);
    chk("nohold1.v", 32'(v_b), 32'h1);
    @(negedge clk);
    reqs_b = 4'b0011; #1;
    chk("nohold2.grants", 32'(grants_b), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_arb_rr_hold.md
Name: bsg_arb_rr_hold

Overview:
- Round-robin arbiter directly downstream of the OR-scan prefix block; consumes its scan output to build the priority mask and one-hot grant.
- Arbitrates width_p requesters onto one shared resource with a valid/yumi handshake.
- Holds a grant stable until the consumer accepts it.
- Sits in front of shared-resource muxes in the arbiter subsystem under BMC.

Parameters:
- width_p, 4, number of requesters (>=1).
- hold_p, 1, 1 = grant locked while v_o=1 and yumi_i=0; 0 = re-arbitrate every cycle.
- tag_width_lp (localparam), max(1,$clog2(width_p)), width of tag_o.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous reset, active-low.
- reqs_i  in  width_p  request vector; bit k = requester k.
- grants_o  out  width_p  one-hot grant (all-zero when v_o=0).
- tag_o  out  tag_width_lp  binary index of granted requester (0 when v_o=0).
- v_o  out  1  a grant is valid.
- yumi_i  in  1  consumer accepts current grant this cycle; legal only when v_o=1.

Behaviour:
- Single clock. Reset is synchronous and active-low (reset_n_i sampled on rising clk_i).
- State:
  - last_r [tag_width_lp]: index of last accepted grant. Reset value width_p-1, so index 0 has top priority after reset.
  - hold_r [1]: reset 0.
  - hold_idx_r [tag_width_lp]: reset 0.
- Outputs while reset_n_i=0: v_o=0, grants_o=0, tag_o=0, regardless of reqs_i.
- FSM, two states:
  - ARB (hold_r=0): grant computed combinationally from reqs_i in the same cycle (0-cycle latency).
  - HOLD (hold_r=1): grants_o = onehot(hold_idx_r).
- Priority in ARB:
  - hi_mask = bits strictly above last_r.
  - If reqs_i & hi_mask is nonzero, grant its lowest set bit; otherwise grant the lowest set bit of reqs_i (wrap-around).
- Lowest-set-bit extraction: lo-to-hi OR-prefix p of the candidate vector; onehot = p & ~(p<<1).
- v_o = |grants_o. tag_o = encode(grants_o).
- Transitions:
  - ARB, v_o=1, yumi_i=1: last_r <= tag_o; stay in ARB.
  - ARB, v_o=1, yumi_i=0, hold_p=1: hold_r <= 1; hold_idx_r <= tag_o.
  - HOLD, yumi_i=1: last_r <= hold_idx_r; hold_r <= 0.
  - HOLD, reqs_i[hold_idx_r]=0 (withdrawal, protocol violation): hold is dropped in the same cycle. Output reverts to the ARB computation and last_r is unchanged. hold_r is re-evaluated per ARB rules.
  - HOLD, yumi_i=0, request still asserted: no change. Changes on other reqs_i bits are ignored.
- yumi_i=1 with v_o=0: ignored, no state change; flagged by a simulation assertion.
- reqs_i=0: v_o=0, no state change.
- width_p=1: grants_o=reqs_i; last_r is constant 0.
- Reset mid-HOLD: hold released. On the first post-reset cycle, priority starts at index 0.
- Accepted grant at index k: next ARB priority is k+1 mod width_p.

Decomposition:
- Shared package bsg_arb_pkg:
  - tag width function (safe_clog2).
  - one-hot/binary encode and decode functions.
  - enum for FSM states {ARB, HOLD}.
- One sub-module: bsg_rr_pick (combinational).
  - Inputs: reqs, last index. Outputs: one-hot pick and tag.
  - Instantiates bsg_scan (or_p=1) on bit-reversed input with the output re-reversed, giving the lo-to-hi prefix.
- Top level holds the state registers, the FSM and the output muxing.

Test Plan (width_p=4, hold_p=1 unless noted):
- After reset, reqs_i=1111, yumi_i=1 every cycle -> grants 0001,0010,0100,1000,0001 on successive cycles, tag_o 0,1,2,3,0.
- last_r=0, reqs_i=0101, yumi_i=1 -> grant 0100 (tag 2); next cycle grant 0001 (wrap).
- reqs_i=0011, yumi_i=0 for 3 cycles, reqs_i becomes 1011 mid-stall -> grants_o stays 0001. Then yumi_i=1 -> next cycle grant 0010.
- HOLD on idx1, reqs_i drops to 1000 with yumi_i=0 -> same cycle grants_o=1000, last_r unchanged.
- HOLD on idx2, reset_n_i=0 one cycle -> v_o=0 during reset. Then reqs_i=1111 -> grant 0001.
- hold_p=0, reqs_i=0011, yumi_i=0, reqs_i changes to 0010 -> grant follows combinationally to 0010, no lock. Separately, yumi_i=1 with reqs_i=0 -> no state change, assertion fires.
